line_window_3x3: RTL
====================

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 Parameters: DataWidth, default 24, pixel width; XADRSWidth, default 11, column address bits; YADRSWidth, default 10, row address bits; RdLatency, default 2, line-buffer RA-to-RD latency in clocks; ADRSWidth = XADRSWidth+YADRSWidth.
REQ-002 Ports, in order: CLK, in, 1, sole clock. RESET, in, 1, asynchronous active-low reset.
REQ-003 DE, HS, VS, in, 1 each, active-high video data-enable and syncs; DIN, in, DataWidth, pixel.
REQ-004 WA, out, ADRSWidth, {row,col} write address; WEN, out, 1; WD, out, DataWidth; these feed line-buffer write side.
REQ-005 RA, out, ADRSWidth; REN, out, 1; these feed line-buffer read side.
REQ-006 RD0, RD1, RD2, in, DataWidth each, line-buffer taps for rows y-1, y-2, y-3.
REQ-007 WIN, out, 9*DataWidth, 3x3 window, slice k=3*r+c; r=0 is RD0 row, c=0 is newest column.
REQ-008 WIN_VALID, WIN_HS, WIN_VS, out, 1 each, window qualifier and aligned syncs.

Function
REQ-009 States: WAIT_VS (reset state), ACTIVE; WAIT_VS->ACTIVE on VS rising edge; no other transition except reset.
REQ-010 In WAIT_VS, WEN, REN, WIN_VALID shall be 0 and DE shall be ignored.
REQ-011 Column counter x shall increment on each ACTIVE clock with DE=1 and clear to 0 on the clock after DE falls.
REQ-012 Row counter y shall increment by 1 on each DE falling edge and clear to 0 on every VS rising edge.
REQ-013 x saturates at 2^XADRSWidth-1; y saturates at 2^YADRSWidth-1; no wrap.
REQ-014 VS rising edge coincident with DE falling: VS clear wins, y=0.
REQ-015 WA={y,x}, WEN=DE, WD=DIN, combinational from registered counters and inputs, zero added latency.
REQ-016 RA={y,x}, REN=DE, same cycle as write.
REQ-017 DE, HS, VS and "row valid" (y>=3) shall be delayed RdLatency clocks to align with RD0..RD2.
REQ-018 On each aligned DE=1, each window row shall shift: col2<=col1, col1<=col0, col0<=RDr; shift freezes when aligned DE=0.
REQ-019 Aligned column counter shall count shifted pixels per line and clear when aligned DE falls.
REQ-020 WIN_VALID=1 exactly when aligned DE=1, aligned row valid=1, and aligned column count>=2 before the shift; registered with WIN.
REQ-021 WIN_HS, WIN_VS = HS, VS delayed RdLatency+1 clocks; total input-to-WIN latency RdLatency+1.
REQ-022 WIN retains last value while WIN_VALID=0.

Reset
REQ-023 RESET=0 asynchronously forces state WAIT_VS, x=y=0, all delay stages, window registers, WIN, WIN_VALID, WIN_HS, WIN_VS to 0.
REQ-024 Reset release mid-frame: no output until next VS rising edge.

Structure
REQ-025 Shared package holds DataWidth, XADRSWidth, YADRSWidth defaults and state encodings WAIT_VS=0, ACTIVE=1.
REQ-026 One sub-module, sync_delay (parameter depth, width), shall implement aligned DE/HS/VS/row-valid delays.
REQ-027 No line-buffer memory inside this block.

Verification
REQ-028 Reset mid-frame, DE toggling, no VS -> WEN=0, WIN_VALID=0 until VS rises.
REQ-029 VS pulse, then 5 lines of 8 pixels, DIN=row*16+col -> WA row field 0..4, col field 0..7 per line, WEN high 8 clocks per line.
REQ-030 Model buffer, RdLatency=2; line 4 col 5 -> WIN_VALID=1, WIN slice 0 = pixel (3,5), slice 8 = pixel (1,3), 3 clocks after DIN.
REQ-031 Lines 0-2 -> WIN_VALID never 1; line 3 -> WIN_VALID high 6 of 8 pixels.
REQ-032 VS rising on the clock DE falls -> next line WA row field = 0.
REQ-033 Line of 2100 DE clocks -> WA col field holds 2047 from pixel 2047 onward.

Source files
------------

// File: rtl/line_window_3x3_pkg.sv
// Shared definitions for the 3x3 line-window block: default widths,
// window geometry, front-end state encoding and the delayed sync payload.
`timescale 1ns/1ps
package line_window_3x3_pkg;

  localparam int DataWidthDefault  = 24;
  localparam int XAdrsWidthDefault = 11;
  localparam int YAdrsWidthDefault = 10;
  localparam int RdLatencyDefault  = 2;

  // Window is WinTaps rows by WinTaps columns.
  localparam int WinTaps = 3;

  // Rows before this index have fewer than three stored lines above them.
  localparam int RowValidMin = 3;

  // A window needs this many previously shifted columns in the current line.
  localparam int ColValidMin = 2;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } state_e;

  // Signals carried alongside the line-buffer read latency.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic row_valid;
  } sync_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth register pipeline used to align video qualifiers with the
// line-buffer read data. A depth of zero is a plain wire.
`timescale 1ns/1ps
module sync_delay #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [Width-1:0] D,
  output logic [Width-1:0] Q
);

  generate
    if (Depth == 0) begin : g_pass
      assign Q = D;
    end else begin : g_pipe
      logic [Width-1:0] stage [Depth];

      // Advance the payload one stage per clock; the last stage is the output.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          for (int i = 0; i < Depth; i++) stage[i] <= '0;
        end else begin
          stage[0] <= D;
          for (int i = 1; i < Depth; i++) stage[i] <= stage[i-1];
        end
      end

      assign Q = stage[Depth-1];
    end
  endgenerate

endmodule

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator. Drives an external line buffer with
// {row,col} addresses, re-aligns the video qualifiers with its read taps
// and assembles a registered 3x3 window with valid and sync outputs.
`timescale 1ns/1ps
module line_window_3x3
  import line_window_3x3_pkg::*;
#(
  parameter  int DataWidth  = DataWidthDefault,
  parameter  int XADRSWidth = XAdrsWidthDefault,
  parameter  int YADRSWidth = YAdrsWidthDefault,
  parameter  int RdLatency  = RdLatencyDefault,
  localparam int ADRSWidth  = XADRSWidth + YADRSWidth
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   DE,
  input  logic                   HS,
  input  logic                   VS,
  input  logic [DataWidth-1:0]   DIN,
  output logic [ADRSWidth-1:0]   WA,
  output logic                   WEN,
  output logic [DataWidth-1:0]   WD,
  output logic [ADRSWidth-1:0]   RA,
  output logic                   REN,
  input  logic [DataWidth-1:0]   RD0,
  input  logic [DataWidth-1:0]   RD1,
  input  logic [DataWidth-1:0]   RD2,
  output logic [9*DataWidth-1:0] WIN,
  output logic                   WIN_VALID,
  output logic                   WIN_HS,
  output logic                   WIN_VS
);

  localparam logic [XADRSWidth-1:0] XMax = '1;
  localparam logic [YADRSWidth-1:0] YMax = '1;
  localparam logic [XADRSWidth-1:0] XOne = XADRSWidth'(1);
  localparam logic [YADRSWidth-1:0] YOne = YADRSWidth'(1);

  // ---------------------------------------------------------------------
  // Front end: frame state, pixel/line counters, line-buffer addressing
  // ---------------------------------------------------------------------
  state_e                state;
  logic [XADRSWidth-1:0] x;
  logic [YADRSWidth-1:0] y;
  logic                  vs_q;
  logic                  de_q;
  logic                  active;
  logic                  vs_rise;
  logic                  de_fall;
  logic                  de_gated;
  logic                  row_valid;

  // Edge detects and gated enables derived from the registered front-end state.
  always_comb begin
    // NOTE: every signal gets a value before any condition, so no path can infer a latch.
    active    = (state == ACTIVE);
    vs_rise   = VS & ~vs_q;
    de_fall   = de_q & ~DE;
    de_gated  = active & DE;
    row_valid = active & (y >= YADRSWidth'(RowValidMin));
  end

  // Frame FSM plus column/row counters; DE is ignored until the first VS edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= WAIT_VS;
      x     <= '0;
      y     <= '0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
    end else begin
      // NOTE: state uses <= so every register here sees the pre-edge values of the others.
      vs_q <= VS;
      // Only DE seen while active can produce a line-end edge.
      de_q <= de_gated;
      case (state)
        WAIT_VS: begin
          x <= '0;
          y <= '0;
          if (vs_rise) state <= ACTIVE;
        end
        ACTIVE: begin
          if (DE) begin
            if (x != XMax) x <= x + XOne;
          end else begin
            x <= '0;
          end
          // A frame start beats a coincident line end.
          if (vs_rise) begin
            y <= '0;
          end else if (de_fall && (y != YMax)) begin
            y <= y + YOne;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  // Write and read share the same address: the buffer returns the rows above.
  assign WA  = {y, x};
  assign WEN = de_gated;
  assign WD  = DIN;
  assign RA  = {y, x};
  assign REN = de_gated;

  // ---------------------------------------------------------------------
  // Alignment of qualifiers with the line-buffer read data
  // ---------------------------------------------------------------------
  sync_t sync_in;
  sync_t sync_al;

  assign sync_in = '{de: de_gated, hs: HS, vs: VS, row_valid: row_valid};

  sync_delay #(
    .Depth (RdLatency),
    .Width ($bits(sync_t))
  ) u_sync_delay (
    .CLK   (CLK),
    .RESET (RESET),
    .D     (sync_in),
    .Q     (sync_al)
  );

  // ---------------------------------------------------------------------
  // Window assembly
  // ---------------------------------------------------------------------
  logic [DataWidth-1:0]   rd_tap       [WinTaps];
  logic [DataWidth-1:0]   win_q        [WinTaps][WinTaps];
  logic [DataWidth-1:0]   win_nxt      [WinTaps][WinTaps];
  logic [9*DataWidth-1:0] win_nxt_flat;
  logic [XADRSWidth-1:0]  acnt;
  logic                   win_fire;

  assign rd_tap[0] = RD0;
  assign rd_tap[1] = RD1;
  assign rd_tap[2] = RD2;

  // Shifted window contents and their packed form (slice 3*r+c, c=0 newest).
  always_comb begin
    win_nxt      = win_q;
    win_nxt_flat = '0;
    for (int r = 0; r < WinTaps; r++) begin
      win_nxt[r][0] = rd_tap[r];
      for (int c = 1; c < WinTaps; c++) win_nxt[r][c] = win_q[r][c-1];
      for (int c = 0; c < WinTaps; c++)
        win_nxt_flat[(WinTaps*r+c)*DataWidth +: DataWidth] = win_nxt[r][c];
    end
  end

  // A window is complete once two earlier columns of this line are held.
  assign win_fire = sync_al.de & sync_al.row_valid &
                    (acnt >= XADRSWidth'(ColValidMin));

  // Shift the window on aligned DE and publish it only when it is complete.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: the window is plain flops rather than RAM, so it resets with everything else; the line-buffer storage sits outside this block.
      for (int r = 0; r < WinTaps; r++)
        for (int c = 0; c < WinTaps; c++) win_q[r][c] <= '0;
      acnt      <= '0;
      WIN       <= '0;
      WIN_VALID <= 1'b0;
      WIN_HS    <= 1'b0;
      WIN_VS    <= 1'b0;
    end else begin
      WIN_HS    <= sync_al.hs;
      WIN_VS    <= sync_al.vs;
      WIN_VALID <= win_fire;
      if (sync_al.de) begin
        win_q <= win_nxt;
        if (acnt != XMax) acnt <= acnt + XOne;
      end else begin
        acnt <= '0;
      end
      if (win_fire) WIN <= win_nxt_flat;
    end
  end

endmodule
